// File: rtl/im_arb.sv
// im_arb: two-requester burst arbiter in front of a single-port image memory.
//
// Requester 0 is the photo copy engine, requester 1 the time overlay engine.
// A granted requester owns the memory port for exactly L+1 beats, where L is
// the length it presented with its request. During ownership its
// addr/wen/wd drive the memory directly. Read data comes back one cycle later
// on the shared rdata bus, qualified by a per-requester rvalid.
//
// Build option (macro IM_ARB_RR_EN):
//   defined   -> round-robin on ties; the requester not most recently granted wins.
//   undefined -> fixed priority; requester 1 always wins ties.
//
// Parameters:
//   AW  memory address width
//   DW  pixel / data width
//   LW  burst-length field width (encoded L gives L+1 beats)
//
// Ports:
//   clk, reset              single clock, asynchronous active-high reset
//   req0/1, len0/1          burst request and its encoded length
//   addr0/1, wen0/1, wd0/1  per-beat address, active-low write enable, write data
//   gnt0/1                  registered grant, high for each owned beat
//   rvalid0/1, rdata        read return, one cycle after an owned read beat
//   IM_A, IM_WEN, IM_D      memory address, active-low write enable, write data
//   IM_Q                    memory read data (one-cycle latency)
module im_arb #(
  parameter int unsigned AW = 20,
  parameter int unsigned DW = 24,
  parameter int unsigned LW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic [LW-1:0] len0,
  input  logic [LW-1:0] len1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic          wen0,
  input  logic          wen1,
  input  logic [DW-1:0] wd0,
  input  logic [DW-1:0] wd1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] IM_A,
  output logic          IM_WEN,
  output logic [DW-1:0] IM_D,
  input  logic [DW-1:0] IM_Q
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          rv0_q, rv0_d;
  logic          rv1_q, rv1_d;

  // Arbitration result for this cycle: when grant is set, sel names the new owner.
  logic          grant;
  logic          sel;
  logic          tie_pick;

`ifdef IM_ARB_RR_EN
  // Most recently granted requester; reset to 1 so requester 0 wins the first tie.
  logic          last_q, last_d;

  assign tie_pick = ~last_q;
`else
  assign tie_pick = 1'b1;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    sel     = 1'b0;
`ifdef IM_ARB_RR_EN
    last_d  = last_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (req0 && req1) begin
          grant = 1'b1;
          sel   = tie_pick;
        end else if (req0) begin
          grant = 1'b1;
          sel   = 1'b0;
        end else if (req1) begin
          grant = 1'b1;
          sel   = 1'b1;
        end
      end
      StOwn0: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LW'(1);
        end else if (req1) begin
          // Hand straight over to the waiting requester, no idle bubble.
          grant = 1'b1;
          sel   = 1'b1;
        end else if (req0) begin
          grant = 1'b1;
          sel   = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      StOwn1: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LW'(1);
        end else if (req0) begin
          grant = 1'b1;
          sel   = 1'b0;
        end else if (req1) begin
          grant = 1'b1;
          sel   = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (grant) begin
      state_d = sel ? StOwn1 : StOwn0;
      cnt_d   = sel ? len1 : len0;
`ifdef IM_ARB_RR_EN
      last_d  = sel;
`endif
    end
  end

  // Read-return tags follow the beat that issued the read, not the current owner,
  // so a read on the last beat still returns to the old owner after a handover.
  always_comb begin
    rv0_d = (state_q == StOwn0) && wen0;
    rv1_d = (state_q == StOwn1) && wen1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

`ifdef IM_ARB_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Memory port mux: the owner drives the port, idle parks it on a harmless read of 0.
  always_comb begin
    IM_A   = '0;
    IM_WEN = 1'b1;
    IM_D   = '0;
    unique case (state_q)
      StOwn0: begin
        IM_A   = addr0;
        IM_WEN = wen0;
        IM_D   = wd0;
      end
      StOwn1: begin
        IM_A   = addr1;
        IM_WEN = wen1;
        IM_D   = wd1;
      end
      default: begin
        IM_A   = '0;
        IM_WEN = 1'b1;
        IM_D   = '0;
      end
    endcase
  end

  assign gnt0    = (state_q == StOwn0);
  assign gnt1    = (state_q == StOwn1);
  assign rvalid0 = rv0_q;
  assign rvalid1 = rv1_q;
  assign rdata   = IM_Q;

endmodule

// File: doc/im_arb.md
IM_ARB -- requirements
Module: im_arb

Interface
REQ-001 Parameter AW, default 20, image-memory address width.
REQ-002 Parameter DW, default 24, image-memory pixel width.
REQ-003 Parameter LW, default 4, burst-length field width; encoded length L means L+1 beats (1..16).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req0 / req1  input  1  requester 0 (photo copy engine) / requester 1 (time overlay engine) burst request.
REQ-007 len0 / len1  input  LW  burst length of the pending request; held stable while reqN=1.
REQ-008 addr0 / addr1  input  AW  beat address, valid while gntN=1.
REQ-009 wen0 / wen1  input  1  beat write enable, active-low (0 = write, 1 = read), valid while gntN=1.
REQ-010 wd0 / wd1  input  DW  beat write data, valid while gntN=1 and wenN=0.
REQ-011 gnt0 / gnt1  output  1  registered grant; high exactly for the burst's beats.
REQ-012 rvalid0 / rvalid1  output  1  read data for that requester is on rdata this cycle.
REQ-013 rdata  output  DW  IM_Q passed through to both requesters.
REQ-014 IM_A  output  AW  memory address.
REQ-015 IM_WEN  output  1  memory write enable, active-low.
REQ-016 IM_D  output  DW  memory write data.
REQ-017 IM_Q  input  DW  memory read data, valid one cycle after a read address.

Function
REQ-018 FSM states: IDLE, OWN0, OWN1; gnt0 = (state==OWN0), gnt1 = (state==OWN1).
REQ-019 IDLE: no request -> stay; one request -> that requester's OWN state next cycle; both -> per arbitration policy (REQ-031).
REQ-020 On entering OWNn, beat counter loads lenN; it decrements on each owned cycle.
REQ-021 Last beat (counter==0): if the other requester is requesting, go directly to its OWN state (no idle bubble); else if the same requester still requests, apply arbitration policy; else IDLE.
REQ-022 Requester must deassert reqN in the cycle of its last beat unless it has a new burst; a req still high at the last beat counts as a new request.
REQ-023 IM_A/IM_WEN/IM_D are a combinational mux of the owner's addr/wen/wd; in IDLE IM_A=0, IM_WEN=1, IM_D=0.
REQ-024 rvalidN asserts one cycle after an owned beat of requester N with wenN=1; tracked by a registered owner-tag, independent of the current owner.
REQ-025 A read on the last beat followed immediately by a grant switch delivers rvalid to the old owner while the new owner drives the port.
REQ-026 Write beats produce no rvalid.
REQ-027 Granted requester cannot abort; beats proceed for L+1 cycles regardless of req.

Reset
REQ-028 On reset assertion, immediately: state=IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, beat counter=0, round-robin pointer=1 (requester 0 favoured first), owner-tag cleared.
REQ-029 Reset mid-burst aborts the burst; any in-flight read is discarded (no rvalid after reset release).
REQ-030 First grant possible in the cycle after reset release.

Configuration
REQ-031 Macro IM_ARB_RR_EN: defined -> round-robin; on a tie the requester not most recently granted wins, pointer updated on each grant; undefined -> fixed priority, requester 1 (time overlay) always wins ties, pointer logic absent.

Verification
REQ-032 req0=1, len0=3, reads at 0x00100..0x00103 -> gnt0 high 4 cycles, IM_WEN=1, rvalid0 high 4 cycles each lagging by 1, rdata=IM_Q.
REQ-033 req1=1, len1=0, write 0xFF00AA @0x00040 -> one-cycle gnt1, IM_WEN=0, IM_D=0xFF00AA, no rvalid1.
REQ-034 req0 and req1 both high from IDLE, len=1 each -> RR build: gnt0 2 cycles then gnt1 2 cycles, no idle gap; fixed build: gnt1 first.
REQ-035 RR build, both hold req with len=0 for 6 cycles -> grants alternate 0,1,0,1,0,1.
REQ-036 Reset asserted on beat 2 of a 4-beat read -> gnt0, rvalid0 drop same cycle; IDLE outputs (IM_A=0, IM_WEN=1); no rvalid after release.
REQ-037 Read last beat of requester 0 with req1 pending -> next cycle gnt1 drives IM_A while rvalid0=1 and rvalid1=0.
